// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state codes
// and the datapath select encodings driven by the controller.
package mc_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states; codes 12-15 are unused
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    // ALU operand B select
    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output table of the multicycle controller: maps the current
// state (plus op in DECODE and mem_ready in FETCH) onto the datapath controls.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_illegal_op
);

    // Every control defaults to 0; each state raises only what it needs
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ASB_B;
        o_alu_op        = ALU_ADD;
        o_pc_source     = PCS_ALU;
        o_illegal_op    = 1'b0;
        case (i_state)
            S_FETCH: begin
                // PC+4 and IR load only on the completing cycle so the PC
                // advances exactly once however long the fetch stalls
                o_mem_read  = 1'b1;
                o_alu_src_b = ASB_FOUR;
                o_pc_write  = i_mem_ready;
                o_ir_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Precompute branch target PC + (imm << 2)
                o_alu_src_b  = ASB_IMM_SH;
                o_illegal_op = !is_legal_op(i_op);
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ASB_IMM;
            end
            S_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                // Held as a level for the whole wait
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCS_JUMP;
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ASB_IMM;
            end
            S_ADDIWB: begin
                o_reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control unit: state register and next-state sequencing;
// output decode is delegated to mc_ctrl_decode.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t r_state;
    state_t w_state_next;
    logic   w_pc_write;
    logic   w_ir_write;

    // Next-state sequencing; unused codes fall back to FETCH
    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_EXEC;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_J:         w_state_next = S_JUMP;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_state_next = S_FETCH;
            S_MEMWR:  w_state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_next = S_ALUWB;
            S_ALUWB:  w_state_next = S_FETCH;
            S_BRANCH: w_state_next = S_FETCH;
            S_JUMP:   w_state_next = S_FETCH;
            S_ADDIEX: w_state_next = S_ADDIWB;
            S_ADDIWB: w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    mc_ctrl_decode u_decode (
        .i_state         (r_state),
        .i_op            (op),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (w_pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_iord          (iord),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (w_ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_source     (pc_source),
        .o_illegal_op    (illegal_op)
    );

    // Reset forces FETCH, whose PC/IR loads must stay quiet while held in reset
    assign pc_write = w_pc_write & rst_n;
    assign ir_write = w_ir_write & rst_n;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: each step pushes the expected state and
// control word to a scoreboard queue, then pops and compares once settled.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] psrc;
        logic       ill;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        outs_t      o;
    } exp_t;

    exp_t  sb[$];
    outs_t got_o;
    int    vectors = 0;
    int    miscompares = 0;
    int    mw_cnt, pcw_cnt, rw_cnt;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] BAD   = 6'b111111;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    assign got_o = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

    // Reference control word for a state, written from the state table
    function automatic outs_t ref_o(input logic [3:0] s, input logic mr,
                                    input logic ill, input logic in_rst);
        outs_t r;
        r = '0;
        case (s)
            4'd0:  begin r.mrd = 1; r.asb = 2'b01; r.pcw = mr & !in_rst; r.irw = mr & !in_rst; end
            4'd1:  begin r.asb = 2'b11; r.ill = ill; end
            4'd2:  begin r.asa = 1; r.asb = 2'b10; end
            4'd3:  begin r.iord = 1; r.mrd = 1; end
            4'd4:  begin r.m2r = 1; r.rwr = 1; end
            4'd5:  begin r.iord = 1; r.mwr = 1; end
            4'd6:  begin r.asa = 1; r.aop = 2'b10; end
            4'd7:  begin r.rdst = 1; r.rwr = 1; end
            4'd8:  begin r.asa = 1; r.aop = 2'b01; r.pcwc = 1; r.psrc = 2'b01; end
            4'd9:  begin r.pcw = 1; r.psrc = 2'b10; end
            4'd10: begin r.asa = 1; r.asb = 2'b10; end
            4'd11: begin r.rwr = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Push the expectation, let outputs settle, then pop and compare
    task automatic check_now(input string tag, input logic [3:0] es, input logic ill,
                             input logic in_rst);
        exp_t e;
        e.st = es;
        e.o  = ref_o(es, mem_ready, ill, in_rst);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        vectors++;
        assert (state === e.st) else begin
            miscompares++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, e.st);
        end
        vectors++;
        assert (got_o === e.o) else begin
            miscompares++;
            $error("FAIL %s outputs: observed %h expected %h", tag, got_o, e.o);
        end
        if (mem_write) mw_cnt++;
        if (pc_write)  pcw_cnt++;
        if (reg_write) rw_cnt++;
        $display("step %-12s op=%b rdy=%b state=%0d ctl=%h", tag, op, mem_ready, state, got_o);
    endtask

    // One clock cycle: drive inputs, check, advance to just past the next edge
    task automatic step(input string tag, input logic [5:0] o, input logic mr,
                        input logic [3:0] es, input logic ill);
        op        = o;
        mem_ready = mr;
        check_now(tag, es, ill, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = RTYPE;
        mem_ready = 1'b1;
        #12;
        // Held in reset: FETCH decode visible, PC/IR loads suppressed
        check_now("reset", 4'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        // LW, zero wait: 0,1,2,3,4,0
        step("lw_fetch",  LW, 1'b1, 4'd0, 1'b0);
        step("lw_decode", LW, 1'b1, 4'd1, 1'b0);
        step("lw_memadr", LW, 1'b1, 4'd2, 1'b0);
        step("lw_memrd",  LW, 1'b1, 4'd3, 1'b0);
        step("lw_memwb",  LW, 1'b1, 4'd4, 1'b0);

        // SW with 3 wait cycles in MEMWR
        step("sw_fetch",  SW, 1'b1, 4'd0, 1'b0);
        pcw_cnt = 0; mw_cnt = 0;
        step("sw_decode", SW, 1'b1, 4'd1, 1'b0);
        step("sw_memadr", SW, 1'b1, 4'd2, 1'b0);
        step("sw_wait1",  SW, 1'b0, 4'd5, 1'b0);
        step("sw_wait2",  SW, 1'b0, 4'd5, 1'b0);
        step("sw_wait3",  SW, 1'b0, 4'd5, 1'b0);
        step("sw_memwr",  SW, 1'b1, 4'd5, 1'b0);
        check_count("sw_mem_write_cycles", mw_cnt, 4);
        check_count("sw_pc_write_cycles", pcw_cnt, 0);

        // Fetch stall of 2 cycles, then R-type
        pcw_cnt = 0;
        step("stall1",    RTYPE, 1'b0, 4'd0, 1'b0);
        step("stall2",    RTYPE, 1'b0, 4'd0, 1'b0);
        step("stall_go",  RTYPE, 1'b1, 4'd0, 1'b0);
        check_count("stall_pc_write_cycles", pcw_cnt, 1);
        step("r_decode",  RTYPE, 1'b1, 4'd1, 1'b0);
        step("r_exec",    RTYPE, 1'b1, 4'd6, 1'b0);
        step("r_aluwb",   RTYPE, 1'b1, 4'd7, 1'b0);

        // BEQ then J, 3 cycles each
        step("beq_fetch",  BEQ, 1'b1, 4'd0, 1'b0);
        step("beq_decode", BEQ, 1'b1, 4'd1, 1'b0);
        step("beq_branch", BEQ, 1'b1, 4'd8, 1'b0);
        step("j_fetch",    JMP, 1'b1, 4'd0, 1'b0);
        step("j_decode",   JMP, 1'b1, 4'd1, 1'b0);
        step("j_jump",     JMP, 1'b1, 4'd9, 1'b0);

        // ADDI, 4 cycles
        step("addi_fetch",  ADDI, 1'b1, 4'd0, 1'b0);
        step("addi_decode", ADDI, 1'b1, 4'd1, 1'b0);
        step("addi_ex",     ADDI, 1'b1, 4'd10, 1'b0);
        step("addi_wb",     ADDI, 1'b1, 4'd11, 1'b0);

        // Illegal opcode: one-cycle pulse, back to FETCH, no writes
        step("bad_fetch",  BAD, 1'b1, 4'd0, 1'b0);
        rw_cnt = 0; mw_cnt = 0;
        step("bad_decode", BAD, 1'b1, 4'd1, 1'b1);
        step("bad_after",  BAD, 1'b0, 4'd0, 1'b0);
        check_count("bad_reg_write_cycles", rw_cnt, 0);
        check_count("bad_mem_write_cycles", mw_cnt, 0);

        // Reset asserted mid-MEMRD
        step("rst_fetch",  LW, 1'b1, 4'd0, 1'b0);
        step("rst_decode", LW, 1'b1, 4'd1, 1'b0);
        step("rst_memadr", LW, 1'b1, 4'd2, 1'b0);
        step("rst_memrd",  LW, 1'b0, 4'd3, 1'b0);
        #2;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        check_now("rst_async", 4'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_now("rst_held", 4'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step("post_fetch",  RTYPE, 1'b1, 4'd0, 1'b0);
        step("post_decode", RTYPE, 1'b1, 4'd1, 1'b0);
        step("post_exec",   RTYPE, 1'b1, 4'd6, 1'b0);
        step("post_aluwb",  RTYPE, 1'b1, 4'd7, 1'b0);
        step("post_end",    RTYPE, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control unit for the CPU datapath. It sequences instruction fetch, decode, execute, memory access and writeback. It drives the IorD select on the instruction/data address mux and every other datapath enable and select. It waits on a memory ready handshake in every state that accesses memory.

Parameters:
OP_W, 6, opcode field width.
ST_W, 4, state register width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
op  input  OP_W  opcode field from instruction register (IR[31:26]).
mem_ready  input  1  memory access completes this cycle.
pc_write  output  1  unconditional PC load.
pc_write_cond  output  1  PC load if ALU zero.
iord  output  1  address mux select: 0 = PC (instruction), 1 = ALUOut (data).
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
ir_write  output  1  instruction register load.
mem_to_reg  output  1  register write data select: 1 = MDR.
reg_dst  output  1  destination select: 1 = rd, 0 = rt.
reg_write  output  1  register file write enable.
alu_src_a  output  1  0 = PC, 1 = A register.
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
illegal_op  output  1  one-cycle pulse on unsupported opcode.
state  output  ST_W  current state, for debug.

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low. rst_n=0 forces state=FETCH immediately.
- Reset mid-operation abandons the instruction; no partial write is retried.
- During reset every output is 0 except those FETCH asserts combinationally: mem_read=1, alu_src_b=01. pc_write=0 and ir_write=0 while rst_n=0.
- States (encoding):
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMRD=3
  - MEMWB=4
  - MEMWR=5
  - EXEC=6
  - ALUWB=7
  - BRANCH=8
  - JUMP=9
  - ADDIEX=10
  - ADDIWB=11
  - Codes 12-15 are unused and go to FETCH on the next edge.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- FETCH:
  - Outputs: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1, so the PC increments exactly once per fetch.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state: LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, J -> JUMP, ADDI -> ADDIEX.
  - Any other opcode -> FETCH, with illegal_op=1 for this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. -> FETCH.
- MEMWR: iord=1, mem_write=1. Holds until mem_ready=1, then goes to FETCH.
  - mem_write stays high for the whole wait; memory must treat it as level, not edge.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. -> FETCH.
- Output decode:
  - All outputs are decoded combinationally from state. The exceptions are FETCH pc_write/ir_write (gated by mem_ready) and illegal_op (gated by op in DECODE).
  - Unlisted outputs are 0 in each state.
- iord is 1 only in MEMRD and MEMWR; it is never 1 while mem_read is asserted for a fetch.
- mem_read and mem_write are never both 1.
- Latencies (cycles, zero-wait memory): R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each wait cycle adds one.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants;
  - state encodings;
  - alu_src_b, alu_op and pc_source encodings.
- Split into one sub-module, mc_ctrl_decode: a purely combinational state+op+mem_ready -> outputs table.
- The FSM register and next-state logic stay in mc_ctrl_fsm.

Test Plan:
- Reset: hold rst_n=0, then assert it low again mid-MEMRD. state=0 asynchronously, pc_write=0, ir_write=0. After release, the first fetch completes with mem_ready=1.
- LW, zero wait: op=100011, mem_ready=1 always. States 0,1,2,3,4,0. iord=1 only in state 3. reg_write=1 and mem_to_reg=1 only in state 4.
- SW with 3 wait cycles: op=101011, mem_ready low for 3 cycles in MEMWR. mem_write=1 for 4 consecutive cycles. pc_write=0 throughout. Returns to FETCH.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH. pc_write and ir_write=0 during the stall, then 1 for exactly one cycle.
- BEQ and J: op=000100 gives pc_write_cond=1 with pc_source=01 in BRANCH. op=000010 gives pc_write=1 with pc_source=10 in JUMP. Both take 3 cycles total.
- Illegal op: op=111111. illegal_op pulses for 1 cycle in DECODE, the next state is FETCH, and no reg_write or mem_write occurs.
